// File: rtl/waveform_gen_pkg.sv
// Shared types and constants for the waveform generator and its measurement block.
package waveform_gen_pkg;

    localparam int LUT_WIDTH       = 8;
    localparam int METER_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLAT    = 2'd1,
        RISING  = 2'd2,
        FALLING = 2'd3
    } dir_state_t;

endpackage

// File: rtl/waveform_dir_detect.sv
// Direction tracker for the sample stream; o_detect flags a rising-to-falling turn
// combinationally on the cycle the turning sample is accepted.
module waveform_dir_detect
    import waveform_gen_pkg::*;
#(
    parameter int DATA_WIDTH = LUT_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clear,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic                         i_valid,
    output logic                         o_detect
);

    dir_state_t                   r_state;
    dir_state_t                   w_state_next;
    logic signed [DATA_WIDTH-1:0] r_prev;
    logic                         w_gt;
    logic                         w_lt;

    assign w_gt = (i_sample > r_prev);
    assign w_lt = (i_sample < r_prev);

    // State and previous-sample registers; only accepted samples advance them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_prev  <= {DATA_WIDTH{1'b0}};
        end else if (i_clear) begin
            r_state <= IDLE;
            r_prev  <= {DATA_WIDTH{1'b0}};
        end else if (i_valid) begin
            r_state <= w_state_next;
            r_prev  <= i_sample;
        end
    end

    // Next-state and detect decode; equal samples always hold the state.
    always_comb begin
        w_state_next = r_state;
        o_detect     = 1'b0;
        if (i_valid) begin
            case (r_state)
                IDLE: w_state_next = FLAT;
                FLAT: begin
                    if (w_gt) begin
                        w_state_next = RISING;
                    end else if (w_lt) begin
                        w_state_next = FALLING;
                    end else begin
                        w_state_next = FLAT;
                    end
                end
                RISING: begin
                    if (w_lt) begin
                        o_detect     = 1'b1;
                        w_state_next = FALLING;
                    end else begin
                        w_state_next = RISING;
                    end
                end
                FALLING: begin
                    if (w_gt) begin
                        w_state_next = RISING;
                    end else begin
                        w_state_next = FALLING;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

endmodule

// File: rtl/waveform_meter.sv
// Peak-to-peak period and per-period min/max meter for a signed sample stream.
// Amplitude tracking is built only when WAVEFORM_METER_AMP_EN is defined.
module waveform_meter
    import waveform_gen_pkg::*;
#(
    parameter int DATA_WIDTH = LUT_WIDTH,
    parameter int CNT_WIDTH  = METER_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic signed [DATA_WIDTH-1:0] sample_i,
    input  logic                         sample_valid_i,
    output logic                         meas_valid_o,
    output logic        [CNT_WIDTH-1:0]  period_o,
    output logic        [DATA_WIDTH-1:0] amp_max_o,
    output logic        [DATA_WIDTH-1:0] amp_min_o,
    output logic                         peak_o,
    output logic                         overflow_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_PRE_SAT = CNT_MAX - CNT_ONE;

    logic                 w_accept;
    logic                 w_detect;
    logic                 w_cnt_sat;
    logic                 w_meas;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_period;
    logic                 r_armed;
    logic                 r_peak;
    logic                 r_meas_valid;
    logic                 r_overflow;

    // A clear in the same cycle discards the sample.
    assign w_accept  = sample_valid_i & ~clear_i;
    assign w_cnt_sat = (r_cnt == CNT_MAX);
    assign w_meas    = w_accept & w_detect & r_armed & ~w_cnt_sat;

    waveform_dir_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dir (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clear  (clear_i),
        .i_sample (sample_i),
        .i_valid  (w_accept),
        .o_detect (w_detect)
    );

    // Period counter, arming and registered period/pulse/overflow outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= {CNT_WIDTH{1'b0}};
            r_period     <= {CNT_WIDTH{1'b0}};
            r_armed      <= 1'b0;
            r_peak       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (clear_i) begin
            r_cnt        <= {CNT_WIDTH{1'b0}};
            r_period     <= {CNT_WIDTH{1'b0}};
            r_armed      <= 1'b0;
            r_peak       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_peak       <= 1'b0;
            r_meas_valid <= 1'b0;
            if (w_accept) begin
                if (w_detect) begin
                    r_peak  <= 1'b1;
                    r_cnt   <= {CNT_WIDTH{1'b0}};
                    r_armed <= 1'b1;
                    if (w_meas) begin
                        r_meas_valid <= 1'b1;
                        r_period     <= r_cnt + CNT_ONE;
                    end
                end else begin
                    if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    if (r_cnt == CNT_PRE_SAT) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign meas_valid_o = r_meas_valid;
    assign period_o     = r_period;
    assign peak_o       = r_peak;
    assign overflow_o   = r_overflow;

`ifdef WAVEFORM_METER_AMP_EN
    logic signed [DATA_WIDTH-1:0] r_run_max;
    logic signed [DATA_WIDTH-1:0] r_run_min;
    logic signed [DATA_WIDTH-1:0] r_amp_max;
    logic signed [DATA_WIDTH-1:0] r_amp_min;
    logic signed [DATA_WIDTH-1:0] w_max_incl;
    logic signed [DATA_WIDTH-1:0] w_min_incl;

    // Running extremes including the current sample.
    always_comb begin
        w_max_incl = r_run_max;
        w_min_incl = r_run_min;
        if (sample_i > r_run_max) begin
            w_max_incl = sample_i;
        end else begin
            w_max_incl = r_run_max;
        end
        if (sample_i < r_run_min) begin
            w_min_incl = sample_i;
        end else begin
            w_min_incl = r_run_min;
        end
    end

    // Running max/min restart from the detecting sample after every detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_max <= {DATA_WIDTH{1'b0}};
            r_run_min <= {DATA_WIDTH{1'b0}};
            r_amp_max <= {DATA_WIDTH{1'b0}};
            r_amp_min <= {DATA_WIDTH{1'b0}};
        end else if (clear_i) begin
            r_run_max <= {DATA_WIDTH{1'b0}};
            r_run_min <= {DATA_WIDTH{1'b0}};
            r_amp_max <= {DATA_WIDTH{1'b0}};
            r_amp_min <= {DATA_WIDTH{1'b0}};
        end else if (w_accept) begin
            if (w_detect) begin
                if (w_meas) begin
                    r_amp_max <= w_max_incl;
                    r_amp_min <= w_min_incl;
                end
                r_run_max <= sample_i;
                r_run_min <= sample_i;
            end else begin
                r_run_max <= w_max_incl;
                r_run_min <= w_min_incl;
            end
        end
    end

    assign amp_max_o = r_amp_max;
    assign amp_min_o = r_amp_min;
`else
    assign amp_max_o = {DATA_WIDTH{1'b0}};
    assign amp_min_o = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_waveform_meter.sv
// Randomized and directed bench for waveform_meter against a sample-history reference model.
module tb_waveform_meter;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int CMAX = 255;
`ifdef WAVEFORM_METER_AMP_EN
    localparam bit AMP_EN = 1'b1;
`else
    localparam bit AMP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_i;
    logic [DW-1:0] sample_i;
    logic          sample_valid_i;
    logic          meas_valid_o;
    logic [CW-1:0] period_o;
    logic [DW-1:0] amp_max_o;
    logic [DW-1:0] amp_min_o;
    logic          peak_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    waveform_meter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .meas_valid_o   (meas_valid_o),
        .period_o       (period_o),
        .amp_max_o      (amp_max_o),
        .amp_min_o      (amp_min_o),
        .peak_o         (peak_o),
        .overflow_o     (overflow_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cycle_no = 0;
    int meas_cnt = 0;
    int last_meas = 0;
    int last_gap = 0;
    bit rnd_clear = 1'b0;

    // Reference model state: accepted-sample history since the last turn.
    bit m_has_prev;
    int m_prev;
    int m_dir;
    bit m_armed;
    int m_since;
    int m_win[$];
    bit e_peak, e_meas, e_ovf;
    int e_period, e_max, e_min;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle_no);
        end
    endtask

    function automatic void model_reset();
        m_has_prev = 1'b0;
        m_prev     = 0;
        m_dir      = 0;
        m_armed    = 1'b0;
        m_since    = 0;
        m_win.delete();
        m_win.push_back(0);
        e_peak = 1'b0; e_meas = 1'b0; e_ovf = 1'b0;
        e_period = 0; e_max = 0; e_min = 0;
    endfunction

    function automatic void model_step(input int s, input bit v, input bit c);
        bit det;
        int mx, mn;
        e_peak = 1'b0;
        e_meas = 1'b0;
        if (c) begin
            model_reset();
            return;
        end
        if (!v) return;
        det = m_has_prev && (m_dir > 0) && (s < m_prev);
        if (m_has_prev && s > m_prev) m_dir = 1;
        else if (m_has_prev && s < m_prev) m_dir = -1;
        m_has_prev = 1'b1;
        m_prev = s;
        m_win.push_back(s);
        if (det) begin
            e_peak = 1'b1;
            if (!m_armed) begin
                m_armed = 1'b1;
            end else if (m_since < CMAX) begin
                e_meas   = 1'b1;
                e_period = m_since + 1;
                if (AMP_EN) begin
                    mx = m_win[0];
                    mn = m_win[0];
                    foreach (m_win[i]) begin
                        if (m_win[i] > mx) mx = m_win[i];
                        if (m_win[i] < mn) mn = m_win[i];
                    end
                    e_max = mx;
                    e_min = mn;
                end
            end
            m_since = 0;
            m_win.delete();
            m_win.push_back(s);
        end else begin
            m_since++;
            if (m_since >= CMAX) e_ovf = 1'b1;
        end
    endfunction

    task automatic cyc(input int s, input bit v, input bit c);
        logic [31:0] sv;
        sv = s;
        sample_i       = sv[DW-1:0];
        sample_valid_i = v;
        clear_i        = c;
        @(posedge clk);
        model_step(s, v, c);
        cycle_no++;
        #1;
        check("peak", int'(peak_o), int'(e_peak));
        check("meas_valid", int'(meas_valid_o), int'(e_meas));
        check("period", int'(period_o), e_period);
        check("amp_max", int'($signed(amp_max_o)), e_max);
        check("amp_min", int'($signed(amp_min_o)), e_min);
        check("overflow", int'(overflow_o), int'(e_ovf));
        if (meas_valid_o) begin
            meas_cnt++;
            last_gap  = cycle_no - last_meas;
            last_meas = cycle_no;
        end
    endtask

    // vm: 0 = valid every cycle, 1 = every other cycle, 2 = random gaps.
    task automatic feed(input int s, input int vm);
        if (rnd_clear && $urandom_range(0, 199) == 0) begin
            cyc(s, 1'b1, 1'b1);
        end
        if (vm == 1) begin
            cyc(s, 1'b1, 1'b0);
            cyc(int'($urandom_range(0, 255)) - 128, 1'b0, 1'b0);
        end else if (vm == 2) begin
            while ($urandom_range(0, 2) == 0) cyc(int'($urandom_range(0, 255)) - 128, 1'b0, 1'b0);
            cyc(s, 1'b1, 1'b0);
        end else begin
            cyc(s, 1'b1, 1'b0);
        end
    endtask

    task automatic tri_wave(input int lo, input int hi, input int nper, input int vm);
        for (int p = 0; p < nper; p++) begin
            for (int k = lo; k < hi; k++) feed(k, vm);
            for (int k = hi; k > lo; k--) feed(k, vm);
        end
    endtask

    task automatic saw_wave(input int lo, input int hi, input int nper, input int vm);
        for (int p = 0; p < nper; p++) begin
            for (int k = lo; k <= hi; k++) feed(k, vm);
        end
    endtask

    int plateau[10] = '{0, 5, 5, 5, 2, 3, 5, 5, 5, 2};

    initial begin
        rst = 1'b1; clear_i = 1'b0; sample_valid_i = 1'b0; sample_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_meas_valid", int'(meas_valid_o), 0);
        check("rst_period", int'(period_o), 0);
        check("rst_peak", int'(peak_o), 0);
        check("rst_overflow", int'(overflow_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Triangle, period 14, valid every cycle.
        meas_cnt = 0;
        tri_wave(0, 7, 4, 0);
        check("tri_meas_cnt", meas_cnt, 3);
        check("tri_period", int'(period_o), 14);
        check("tri_max", int'($signed(amp_max_o)), AMP_EN ? 7 : 0);
        check("tri_min", int'($signed(amp_min_o)), 0);

        // Sawtooth -5..4, valid every other cycle.
        cyc(0, 1'b1, 1'b1);
        meas_cnt = 0;
        saw_wave(-5, 4, 4, 1);
        check("saw_meas_cnt", meas_cnt, 2);
        check("saw_period", int'(period_o), 10);
        check("saw_gap", last_gap, 20);
        check("saw_max", int'($signed(amp_max_o)), AMP_EN ? 4 : 0);
        check("saw_min", int'($signed(amp_min_o)), AMP_EN ? -5 : 0);

        // Counter saturation while armed, then recovery.
        tri_wave(0, 7, 1, 0);
        meas_cnt = 0;
        for (int i = 0; i < 260; i++) feed(3, 0);
        check("sat_overflow", int'(overflow_o), 1);
        check("sat_meas_cnt", meas_cnt, 0);
        tri_wave(0, 7, 3, 0);
        check("sat_recover_cnt", meas_cnt, 3);
        check("sat_recover_period", int'(period_o), 14);
        check("sat_overflow_sticky", int'(overflow_o), 1);

        // Plateau of equal samples holds the rising state.
        cyc(0, 1'b1, 1'b1);
        foreach (plateau[i]) feed(plateau[i], 0);
        check("plateau_period", int'(period_o), 5);

        // Clear mid-period with a valid sample.
        tri_wave(0, 7, 2, 0);
        for (int k = 0; k < 4; k++) feed(k, 0);
        cyc(9, 1'b1, 1'b1);
        check("clr_period", int'(period_o), 0);
        check("clr_peak", int'(peak_o), 0);
        check("clr_overflow", int'(overflow_o), 0);
        meas_cnt = 0;
        tri_wave(0, 7, 2, 0);
        check("clr_rearm_cnt", meas_cnt, 1);

        // Asynchronous reset between clock edges.
        tri_wave(0, 7, 2, 0);
        for (int k = 0; k < 5; k++) feed(k, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_meas_valid", int'(meas_valid_o), 0);
        check("arst_period", int'(period_o), 0);
        check("arst_amp_max", int'(amp_max_o), 0);
        check("arst_amp_min", int'(amp_min_o), 0);
        check("arst_peak", int'(peak_o), 0);
        check("arst_overflow", int'(overflow_o), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        meas_cnt = 0;
        tri_wave(0, 7, 4, 0);
        check("arst_meas_cnt", meas_cnt, 3);
        check("arst_period_after", int'(period_o), 14);

        // Randomized segments with occasional clears.
        rnd_clear = 1'b1;
        for (int seg = 0; seg < 80; seg++) begin
            int kind, lo, hi, vm;
            kind = int'($urandom_range(0, 2));
            vm   = int'($urandom_range(0, 2));
            lo   = int'($urandom_range(0, 100)) - 100;
            hi   = lo + 1 + int'($urandom_range(0, 60));
            if (kind == 0) begin
                tri_wave(lo, hi, int'($urandom_range(1, 3)), vm);
            end else if (kind == 1) begin
                saw_wave(lo, hi, int'($urandom_range(1, 3)), vm);
            end else begin
                for (int i = 0; i < 30; i++) feed(int'($urandom_range(0, 255)) - 128, vm);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
